// File: rtl/window_extractor_v2.sv
// -----------------------------------------------------------------------------
// window_extractor_v2
//
// Extracts a WIN_W x WIN_H pixel window from a raster pixel stream. Pixels are
// qualified by in_valid (stalls are allowed), in_sof resynchronises the
// coordinate counters, and win_valid is raised only when the whole window lies
// inside the frame.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_data carries a pixel this cycle (always accepted)
//   in_sof     in   with in_valid: pixel (0,0) of a new frame
//   in_data    in   pixel, raster order
//   win_valid  out  win_data holds a complete in-frame window
//   win_data   out  window taps; element (i,j) at DATA_W*(i*WIN_W+j),
//                   (0,0) is the newest pixel, j = older columns, i = older lines
//   win_x      out  column of the newest pixel in the window
//   win_y      out  row of the newest pixel in the window
//   frame_done out  one-cycle pulse after the last pixel of a frame is accepted
// -----------------------------------------------------------------------------
module window_extractor_v2 #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned FRAME_W = 640,
    parameter int unsigned FRAME_H = 480,
    parameter int unsigned WIN_W   = 3,
    parameter int unsigned WIN_H   = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    input  logic                            in_sof,
    input  logic [DATA_W-1:0]               in_data,
    output logic                            win_valid,
    output logic [WIN_W*WIN_H*DATA_W-1:0]   win_data,
    output logic [CNT_W-1:0]                win_x,
    output logic [CNT_W-1:0]                win_y,
    output logic                            frame_done
);

    // Enough history to reach the oldest tap: WIN_H-1 full lines plus WIN_W pixels.
    localparam int unsigned CHAIN_LEN = (WIN_H - 1) * FRAME_W + WIN_W;

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(FRAME_H - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic accept;
    assign accept = in_valid;

    // -------------------------------------------------------------------------
    // Pixel shift chain. Deliberately without reset so it can map onto
    // SRL/BRAM; taps are don't-care until the first win_valid.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] chain_q [CHAIN_LEN];

    always_ff @(posedge clk) begin
        if (accept) begin
            chain_q[0] <= in_data;
            for (int k = 1; k < int'(CHAIN_LEN); k++) begin
                chain_q[k] <= chain_q[k-1];
            end
        end
    end

    for (genvar i = 0; i < int'(WIN_H); i++) begin : g_tap_row
        for (genvar j = 0; j < int'(WIN_W); j++) begin : g_tap_col
            assign win_data[DATA_W*(i*WIN_W+j) +: DATA_W] = chain_q[i*FRAME_W+j];
        end
    end

    // -------------------------------------------------------------------------
    // Coordinate tracking. col_q/row_q hold the position the next accepted
    // pixel will occupy; in_sof overrides that to (0,0).
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] pix_col, pix_row;
    logic             at_last_col, at_last_row;
    logic             col_ok, row_ok;

    always_comb begin
        pix_col     = in_sof ? '0 : col_q;
        pix_row     = in_sof ? '0 : row_q;
        at_last_col = (pix_col == LAST_COL);
        at_last_row = (pix_row == LAST_ROW);

        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (at_last_col) begin
                col_d = '0;
                row_d = at_last_row ? '0 : pix_row + ONE;
            end else begin
                col_d = pix_col + ONE;
                row_d = pix_row;
            end
        end
    end

    // Window fits left/up of the newest pixel. Split out so a 1-wide or
    // 1-high window does not produce an always-true unsigned compare.
    if (WIN_W > 1) begin : g_col_chk
        assign col_ok = (pix_col >= CNT_W'(WIN_W - 1));
    end else begin : g_col_any
        assign col_ok = 1'b1;
    end

    if (WIN_H > 1) begin : g_row_chk
        assign row_ok = (pix_row >= CNT_W'(WIN_H - 1));
    end else begin : g_row_any
        assign row_ok = 1'b1;
    end

    // -------------------------------------------------------------------------
    // Registered outputs, aligned with the chain update on the same edge.
    // -------------------------------------------------------------------------
    logic             win_valid_q, win_valid_d;
    logic [CNT_W-1:0] win_x_q, win_x_d;
    logic [CNT_W-1:0] win_y_q, win_y_d;
    logic             frame_done_q, frame_done_d;

    always_comb begin
        win_valid_d  = accept && col_ok && row_ok;
        win_x_d      = accept ? pix_col : win_x_q;
        win_y_d      = accept ? pix_row : win_y_q;
        // A resync pixel is never the end of a frame, even in a 1x1 frame.
        frame_done_d = accept && !in_sof && at_last_col && at_last_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            win_x_q      <= '0;
            win_y_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            win_x_q      <= win_x_d;
            win_y_q      <= win_y_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_x      = win_x_q;
    assign win_y      = win_y_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_extractor_v2.sv
// -----------------------------------------------------------------------------
// tb_window_extractor_v2
//
// Bench for window_extractor_v2: an 8x4 frame with a 3x3 window driven from a
// table of per-pixel expectations, plus a 4x2 frame with a 1x1 window.
// -----------------------------------------------------------------------------
module tb_window_extractor_v2;

    localparam int DW = 8;
    localparam int FW = 8;
    localparam int FH = 4;
    localparam int WW = 3;
    localparam int WH = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // 3x3 instance
    logic                  in_valid = 1'b0;
    logic                  in_sof = 1'b0;
    logic [DW-1:0]         in_data = '0;
    logic                  win_valid;
    logic [WW*WH*DW-1:0]   win_data;
    logic [CW-1:0]         win_x;
    logic [CW-1:0]         win_y;
    logic                  frame_done;

    // 1x1 instance
    logic                  v1 = 1'b0;
    logic                  s1 = 1'b0;
    logic [DW-1:0]         d1 = '0;
    logic                  wv1;
    logic [DW-1:0]         wd1;
    logic [CW-1:0]         wx1;
    logic [CW-1:0]         wy1;
    logic                  fd1;

    always #5 clk = ~clk;

    window_extractor_v2 #(
        .DATA_W (DW), .FRAME_W(FW), .FRAME_H(FH), .WIN_W(WW), .WIN_H(WH), .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .win_valid (win_valid),
        .win_data  (win_data),
        .win_x     (win_x),
        .win_y     (win_y),
        .frame_done(frame_done)
    );

    window_extractor_v2 #(
        .DATA_W (DW), .FRAME_W(4), .FRAME_H(2), .WIN_W(1), .WIN_H(1), .CNT_W(CW)
    ) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .in_sof    (s1),
        .in_data   (d1),
        .win_valid (wv1),
        .win_data  (wd1),
        .win_x     (wx1),
        .win_y     (wy1),
        .frame_done(fd1)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          sof;
        logic          valid;
        int            x;
        int            y;
        logic          done;
        logic [DW-1:0] t00;
        logic [DW-1:0] t02;
        logic [DW-1:0] t20;
        logic [DW-1:0] t22;
    } vec_t;

    vec_t          vecs[FW*FH];
    vec_t          sbq[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_win;
    int            n_done;
    int            first_valid;
    logic [DW-1:0] last_data = '0;
    int            last_x = 0;
    int            last_y = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] tap(input int i, input int j);
        return win_data[DW*(i*WW+j) +: DW];
    endfunction

    // One accepted pixel on the 3x3 instance; expectation goes through the queue.
    task automatic apply(input vec_t v, input logic sof);
        vec_t e;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = v.data;
        sbq.push_back(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sbq.pop_front();
            chk("win_valid", {63'd0, win_valid}, {63'd0, e.valid});
            chk("win_x", 64'(win_x), 64'(e.x));
            chk("win_y", 64'(win_y), 64'(e.y));
            chk("frame_done", {63'd0, frame_done}, {63'd0, e.done});
            if (e.valid) begin
                chk("tap00", 64'(tap(0, 0)), 64'(e.t00));
                chk("tap02", 64'(tap(0, 2)), 64'(e.t02));
                chk("tap20", 64'(tap(2, 0)), 64'(e.t20));
                chk("tap22", 64'(tap(2, 2)), 64'(e.t22));
            end
            last_data = e.data;
            last_x    = e.x;
            last_y    = e.y;
        end
        if (win_valid) n_win++;
        if (frame_done) n_done++;
    endtask

    // One idle cycle: flags low, coordinates and newest tap hold.
    task automatic idle();
        in_valid = 1'b0;
        in_sof   = 1'b1;  // must be ignored without in_valid
        @(posedge clk);
        #1;
        in_sof = 1'b0;
        chk("idle_win_valid", {63'd0, win_valid}, 64'd0);
        chk("idle_frame_done", {63'd0, frame_done}, 64'd0);
        chk("idle_win_x", 64'(win_x), 64'(last_x));
        chk("idle_win_y", 64'(win_y), 64'(last_y));
        chk("idle_tap00", 64'(tap(0, 0)), 64'(last_data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expectations for one frame with in_data = pixel index.
        for (int p = 0; p < FW*FH; p++) begin
            vecs[p].data  = DW'(p);
            vecs[p].sof   = (p == 0);
            vecs[p].x     = p % FW;
            vecs[p].y     = p / FW;
            vecs[p].valid = (vecs[p].x >= WW-1) && (vecs[p].y >= WH-1);
            vecs[p].done  = (p == FW*FH-1);
            vecs[p].t00   = DW'(p);
            vecs[p].t02   = DW'(p - 2);
            vecs[p].t20   = DW'(p - 2*FW);
            vecs[p].t22   = DW'(p - 2*FW - 2);
        end

        // Reset state
        #12;
        chk("rst_win_valid", {63'd0, win_valid}, 64'd0);
        chk("rst_win_x", 64'(win_x), 64'd0);
        chk("rst_win_y", 64'(win_y), 64'd0);
        chk("rst_frame_done", {63'd0, frame_done}, 64'd0);
        chk("rst_1x1_valid", {63'd0, wv1}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous frame
        n_win = 0; n_done = 0;
        for (int p = 0; p < FW*FH; p++) apply(vecs[p], vecs[p].sof);
        chk("cont_window_count", 64'(n_win), 64'd12);
        chk("cont_done_count", 64'(n_done), 64'd1);

        // Same frame with an idle cycle after every pixel
        n_win = 0; n_done = 0;
        for (int p = 0; p < FW*FH; p++) begin
            apply(vecs[p], vecs[p].sof);
            idle();
        end
        chk("gap_window_count", 64'(n_win), 64'd12);
        chk("gap_done_count", 64'(n_done), 64'd1);

        // Mid-frame resync: abort after 13 pixels, new sof on the 14th
        n_win = 0; n_done = 0;
        for (int p = 0; p < 13; p++) apply(vecs[p], vecs[p].sof);
        chk("aborted_done_count", 64'(n_done), 64'd0);
        n_win = 0; n_done = 0; first_valid = -1;
        for (int p = 0; p < FW*FH; p++) begin
            apply(vecs[p], vecs[p].sof);
            if (win_valid && first_valid < 0) first_valid = p;
        end
        chk("resync_first_valid", 64'(first_valid), 64'd18);
        chk("resync_window_count", 64'(n_win), 64'd12);
        chk("resync_done_count", 64'(n_done), 64'd1);

        // Asynchronous reset mid-frame, between clock edges
        for (int p = 0; p <= 20; p++) apply(vecs[p], vecs[p].sof);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_win_valid", {63'd0, win_valid}, 64'd0);
        chk("async_rst_win_x", 64'(win_x), 64'd0);
        chk("async_rst_win_y", 64'(win_y), 64'd0);
        chk("async_rst_frame_done", {63'd0, frame_done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // No sof after reset: counting starts at (0,0), then wraps naturally
        for (int f = 0; f < 2; f++) begin
            n_win = 0; n_done = 0;
            for (int p = 0; p < FW*FH; p++) apply(vecs[p], 1'b0);
            chk("nosof_window_count", 64'(n_win), 64'd12);
            chk("nosof_done_count", 64'(n_done), 64'd1);
        end

        // Degenerate 1x1 window on a 4x2 frame
        for (int k = 0; k < 10; k++) begin
            logic [DW-1:0] d;
            d  = DW'($urandom_range(0, 255));
            v1 = 1'b1;
            d1 = d;
            @(posedge clk);
            #1;
            v1 = 1'b0;
            chk("w1_valid", {63'd0, wv1}, 64'd1);
            chk("w1_data", 64'(wd1), 64'(d));
            chk("w1_x", 64'(wx1), 64'(k % 4));
            chk("w1_y", 64'(wy1), 64'((k / 4) % 2));
            chk("w1_done", {63'd0, fd1}, {63'd0, (k % 8) == 7});
            if (k == 5) begin
                @(posedge clk);
                #1;
                chk("w1_idle_valid", {63'd0, wv1}, 64'd0);
                chk("w1_idle_data", 64'(wd1), 64'(d));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/window_extractor_v2.md
Name: window_extractor_v2

Overview:
Parametrised successor to the plain shift-register window tap. Extracts a WIN_W x WIN_H pixel window from a raster pixel stream. Adds over the first generation: async active-low reset, input valid qualification (stall support), start-of-frame resync, row/column tracking, and a window-valid flag that is asserted only when the whole window lies inside the frame. Sits between the camera/pixel source and the per-window filter kernels.

Parameters:
DATA_W, 8, bits per pixel
FRAME_W, 640, pixels per line (>= WIN_W)
FRAME_H, 480, lines per frame (>= WIN_H)
WIN_W, 3, window width in pixels (>= 1)
WIN_H, 3, window height in lines (>= 1)
CNT_W, 16, width of the coordinate counters (must hold FRAME_W-1 and FRAME_H-1)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  in_data is a pixel this cycle
in_sof  in  1  qualified by in_valid; marks pixel (0,0) of a new frame
in_data  in  DATA_W  pixel, raster order
win_valid  out  1  win_data holds a complete in-frame window
win_data  out  WIN_W*WIN_H*DATA_W  window taps
win_x  out  CNT_W  column of newest pixel in the window
win_y  out  CNT_W  row of newest pixel in the window
frame_done  out  1  one-cycle pulse: last pixel of the frame was accepted

Behaviour:
- Accept = in_valid high at a rising clk edge. There is no backpressure and no ready signal; the block always accepts.
- Storage: a shift chain of DATA_W*((WIN_H-1)*FRAME_W+WIN_W) bits. It advances by one pixel only on accept, with the new pixel entering at slot 0. With in_valid low, the chain and all taps hold.
- Tap mapping: win_data[DATA_W*(i*WIN_W+j) +: DATA_W] = chain slot i*FRAME_W+j. Element (0,0) is the newest pixel. j increasing = older columns; i increasing = older lines.
- The chain is not reset, so it can be mapped to SRL/BRAM. win_data is a direct tap of the chain and is undefined until the first win_valid.
- Counters col/row: reset to 0, and advance only on accept.
  - in_sof on accept: the pixel is (0,0). The next expected position is col=1, row=0, regardless of prior state (mid-frame resync). Chain contents are not cleared.
  - Otherwise: the pixel is (col,row). col increments; at FRAME_W-1, col wraps to 0 and row increments. At (FRAME_W-1, FRAME_H-1), both wrap to 0.
- Registered outputs, updated on the same edge the pixel is accepted (latency 1 cycle, taps and flag aligned):
  - win_valid = accept AND pix_col >= WIN_W-1 AND pix_row >= WIN_H-1; 0 on cycles with no accept.
  - win_x/win_y = pix_col/pix_row of the accepted pixel; held when there is no accept.
  - frame_done = accept AND pixel is (FRAME_W-1, FRAME_H-1) AND in_sof low; otherwise 0.
- Pixels received before the first in_sof after reset are still counted from the reset position (0,0).
- in_sof when in_valid is low is ignored.
- Reset values: win_valid=0, win_x=0, win_y=0, frame_done=0, internal col=row=0.
- Reset asserted mid-frame: counters and flags clear immediately (asynchronously). The first accepted pixel after release is (0,0).
- Edge wrap: windows straddling a line boundary (pix_col < WIN_W-1) are never flagged valid. Their taps contain mixed-line data and must be ignored downstream.
- WIN_W=1 or WIN_H=1 degenerate cases are legal. A 1x1 window is valid on every accept.

Test Plan:
- FRAME_W=8, FRAME_H=4, 3x3, in_data=pixel index, in_sof on pixel 0, continuous valid -> win_valid first high the cycle after pixel 18 (x=2,y=2). Taps (0,0)=18, (0,2)=16, (2,0)=2, (2,2)=0. Exactly 12 valid windows per frame. frame_done pulses once, after pixel 31.
- Same stream with in_valid toggling 1/0 every cycle -> identical sequence of valid windows and taps. win_valid is never high on a cycle following an idle input cycle. win_x/win_y and win_data hold across gaps.
- Line wrap: pixels 16..17 (x=0,1, y=2) -> win_valid=0. Pixel 18 -> win_valid=1, win_x=2, win_y=2.
- Mid-frame resync: in_sof asserted at pixel 13 of frame 1 -> that pixel reports x=0,y=0 with win_valid=0. The next valid window is 18 accepts later. No frame_done for the aborted frame.
- Reset: assert rst_n=0 asynchronously mid-frame -> win_valid, frame_done, win_x, win_y go to 0 without a clock edge. After release, the first pixel reports (0,0).
- Degenerate 1x1, FRAME_W=4, FRAME_H=2 -> win_valid high on every accept, and win_data equals the last accepted pixel.
